// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the EX-stage control and the iterative multiply/divide unit.
// Signal names match the original flat port list so existing connections map one-to-one.
interface mult_div_unit_if #(
    parameter int unsigned DW = 32
);
    logic          i_start;
    logic [2:0]    i_op;
    logic [DW-1:0] i_rs;
    logic [DW-1:0] i_rt;
    logic          o_busy;
    logic          o_done;
    logic [DW-1:0] o_hi;
    logic [DW-1:0] o_lo;

    modport master (
        output i_start, i_op, i_rs, i_rt,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_rs, i_rt,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; one radix-2 step per cycle, DW steps,
// followed by a sign-fix cycle that writes HI/LO and pulses o_done.
module mult_div_unit #(
    parameter int unsigned DW = 32
) (
    input logic            i_clk,
    input logic            i_rst_n,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(DW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    // Multiply: {partial product, remaining multiplier}; divide: low half is dividend -> quotient.
    logic [2*DW-1:0] acc;
    logic [DW-1:0]   rem;
    logic [DW-1:0]   opd;
    logic [DW-1:0]   rs_raw;
    logic            is_mul, neg_lo, neg_hi, div_zero;
    logic [DW-1:0]   hi_q, lo_q;
    logic            busy_q, done_q;

    logic            is_signed, rs_neg, rt_neg;
    logic [DW-1:0]   rs_abs, rt_abs;
    logic [DW:0]     mul_sum, div_shift, div_trial;
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quo_fix, rem_fix;

    always_comb begin
        is_signed = ~bus.i_op[0];
        rs_neg    = is_signed & bus.i_rs[DW-1];
        rt_neg    = is_signed & bus.i_rt[DW-1];
        rs_abs    = rs_neg ? -bus.i_rs : bus.i_rs;
        rt_abs    = rt_neg ? -bus.i_rt : bus.i_rt;
        mul_sum   = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opd} : '0);
        div_shift = {rem, acc[DW-1]};
        div_trial = div_shift - {1'b0, opd};
        prod_fix  = neg_lo ? -acc : acc;
        quo_fix   = neg_lo ? -acc[DW-1:0] : acc[DW-1:0];
        rem_fix   = neg_hi ? -rem : rem;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            opd      <= '0;
            rs_raw   <= '0;
            is_mul   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        case (bus.i_op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_mul   <= ~bus.i_op[1];
                                acc      <= {{DW{1'b0}}, (bus.i_op[1] ? rs_abs : rt_abs)};
                                opd      <= bus.i_op[1] ? rt_abs : rs_abs;
                                rem      <= '0;
                                rs_raw   <= bus.i_rs;
                                neg_lo   <= rs_neg ^ rt_neg;
                                neg_hi   <= bus.i_op[1] ? rs_neg : (rs_neg ^ rt_neg);
                                div_zero <= bus.i_op[1] & (bus.i_rt == '0);
                                cnt      <= '0;
                                busy_q   <= 1'b1;
                                state    <= S_ITER;
                            end
                            3'b100:  hi_q <= bus.i_rs;
                            3'b101:  lo_q <= bus.i_rs;
                            default: ;
                        endcase
                    end
                end
                S_ITER: begin
                    if (is_mul) begin
                        acc <= {mul_sum, acc[DW-1:1]};
                    end else begin
                        // Restoring step: keep the trial remainder only when it did not go negative.
                        acc <= {acc[2*DW-1:DW], acc[DW-2:0], ~div_trial[DW]};
                        rem <= div_trial[DW] ? div_shift[DW-1:0] : div_trial[DW-1:0];
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DW-1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (is_mul) begin
                        hi_q <= prod_fix[2*DW-1:DW];
                        lo_q <= prod_fix[DW-1:0];
                    end else if (div_zero) begin
                        hi_q <= rs_raw;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if #(.DW(DW)) ifc ();

    mult_div_unit #(.DW(DW)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (ifc.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt, hi, lo;
    } vec_t;

    function automatic void model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      p;
        logic [63:0] u;
        hi = '0;
        lo = '0;
        case (op)
            3'd0: begin
                p  = longint'($signed(rs)) * longint'($signed(rt));
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd1: begin
                u  = {32'd0, rs} * {32'd0, rt};
                hi = u[63:32];
                lo = u[31:0];
            end
            3'd2: begin
                if (rt == 32'd0) begin
                    lo = 32'hFFFFFFFF; hi = rs;
                end else if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) begin
                    lo = 32'h80000000; hi = 32'd0;
                end else begin
                    lo = $signed(rs) / $signed(rt);
                    hi = $signed(rs) % $signed(rt);
                end
            end
            3'd3: begin
                if (rt == 32'd0) begin
                    lo = 32'hFFFFFFFF; hi = rs;
                end else begin
                    lo = rs / rt;
                    hi = rs % rt;
                end
            end
            default: ;
        endcase
    endfunction

    // Called at a falling edge; issues the op now and returns at the falling edge where o_done is seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int lat, output int bcnt, output bit held, output bit seen);
        logic [31:0] h0, l0;
        int k;
        h0 = ifc.o_hi; l0 = ifc.o_lo;
        held = 1'b1; bcnt = 0; k = 0;
        ifc.i_start = 1'b1; ifc.i_op = op; ifc.i_rs = rs; ifc.i_rt = rt;
        do begin
            @(negedge clk);
            k++;
            ifc.i_start = 1'b0;
            if (ifc.o_busy) bcnt++;
            if (!ifc.o_done && (ifc.o_hi !== h0 || ifc.o_lo !== l0)) held = 1'b0;
        end while (!ifc.o_done && k < 100);
        seen = ifc.o_done;
        lat  = k - 1;
        hi   = ifc.o_hi;
        lo   = ifc.o_lo;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({ifc.o_busy, ifc.o_done, ifc.o_hi, ifc.o_lo} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero",
                     ifc.o_busy, ifc.o_done, ifc.o_hi, ifc.o_lo);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult_latency();
        logic [31:0] hi, lo; int lat, bcnt; bit held, seen;
        run_op(3'd0, 32'hFFFFFFFD, 32'd7, hi, lo, lat, bcnt, held, seen);
        vectors++;
        if (!seen || lat !== 33) begin
            miscompares++; $display("FAIL mult_latency: seen=%b lat=%0d, want 33", seen, lat);
        end
        vectors++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            miscompares++; $display("FAIL mult_neg3x7: hi=%h lo=%h, want FFFFFFFF FFFFFFEB", hi, lo);
        end
        vectors++;
        if (bcnt !== 33) begin
            miscompares++; $display("FAIL busy_cycles: got %0d, want 33", bcnt);
        end
        vectors++;
        if (!held) begin
            miscompares++; $display("FAIL hilo_hold: hi/lo changed during ITER, want held");
        end
        @(negedge clk);
        vectors++;
        if (ifc.o_done !== 1'b0 || ifc.o_busy !== 1'b0) begin
            miscompares++; $display("FAIL done_pulse: done=%b busy=%b, want 0 0", ifc.o_done, ifc.o_busy);
        end
    endtask

    task automatic test_directed();
        vec_t tab [7];
        logic [31:0] hi, lo; int lat, bcnt; bit held, seen;
        tab[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tab[1] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tab[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tab[3] = '{3'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        tab[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tab[5] = '{3'd3, 32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA};
        tab[6] = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            run_op(tab[i].op, tab[i].rs, tab[i].rt, hi, lo, lat, bcnt, held, seen);
            vectors++;
            if (!seen || hi !== tab[i].hi || lo !== tab[i].lo || lat !== 33) begin
                miscompares++;
                $display("FAIL directed[%0d] op=%0d rs=%h rt=%h: hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=33",
                         i, tab[i].op, tab[i].rs, tab[i].rt, hi, lo, lat, tab[i].hi, tab[i].lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo, eh, el, rs, rt; logic [2:0] op; int lat, bcnt; bit held, seen;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            op = 3'(i); rs = $urandom; rt = $urandom;
            model(op, rs, rt, eh, el);
            run_op(op, rs, rt, hi, lo, lat, bcnt, held, seen);
            vectors++;
            if (!seen || hi !== eh || lo !== el || lat !== 33) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=33",
                         i, hi, lo, lat, eh, el);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] hi, lo, eh, el, rs, rt; logic [2:0] op; int lat, bcnt; bit held, seen;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            rs = $urandom; rt = $urandom;
            case ($urandom_range(0, 7))
                0: rt = 32'd0;
                1: rs = 32'h80000000;
                2: rt = 32'hFFFFFFFF;
                3: rt = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(op, rs, rt, eh, el);
            @(negedge clk);
            run_op(op, rs, rt, hi, lo, lat, bcnt, held, seen);
            vectors++;
            if (!seen || hi !== eh || lo !== el || lat !== 33 || bcnt !== 33 || !held) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d rs=%h rt=%h: hi=%h lo=%h lat=%0d busy=%0d held=%b, want hi=%h lo=%h lat=33 busy=33 held=1",
                         i, op, rs, rt, hi, lo, lat, bcnt, held, eh, el);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int k;
        @(negedge clk);
        ifc.i_start = 1'b1; ifc.i_op = 3'd0; ifc.i_rs = 32'd3; ifc.i_rt = 32'd5;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 5) begin
                ifc.i_start = 1'b1; ifc.i_op = 3'd4; ifc.i_rs = 32'h12345678;
            end else begin
                ifc.i_start = 1'b0;
            end
        end while (!ifc.o_done && k < 100);
        vectors++;
        if (!ifc.o_done || ifc.o_hi !== 32'd0 || ifc.o_lo !== 32'd15 || k !== 34) begin
            miscompares++;
            $display("FAIL mthi_while_busy: done=%b hi=%h lo=%h edges=%0d, want 1 00000000 0000000F 33",
                     ifc.o_done, ifc.o_hi, ifc.o_lo, k - 1);
        end
    endtask

    task automatic test_mtlo();
        logic [31:0] h0, l0;
        @(negedge clk);
        h0 = ifc.o_hi;
        ifc.i_start = 1'b1; ifc.i_op = 3'd5; ifc.i_rs = 32'h0000ABCD;
        @(negedge clk);
        ifc.i_start = 1'b0;
        vectors++;
        if (ifc.o_lo !== 32'h0000ABCD || ifc.o_hi !== h0 || ifc.o_busy !== 1'b0 || ifc.o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo_idle: lo=%h hi=%h busy=%b done=%b, want 0000ABCD %h 0 0",
                     ifc.o_lo, ifc.o_hi, ifc.o_busy, ifc.o_done, h0);
        end
        ifc.i_start = 1'b1; ifc.i_op = 3'd4; ifc.i_rs = 32'hCAFE0001;
        @(negedge clk);
        ifc.i_start = 1'b0;
        vectors++;
        if (ifc.o_hi !== 32'hCAFE0001 || ifc.o_lo !== 32'h0000ABCD || ifc.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi_idle: hi=%h lo=%h busy=%b, want CAFE0001 0000ABCD 0", ifc.o_hi, ifc.o_lo, ifc.o_busy);
        end
        h0 = ifc.o_hi; l0 = ifc.o_lo;
        ifc.i_start = 1'b1; ifc.i_op = 3'd6; ifc.i_rs = 32'h5555AAAA;
        @(negedge clk);
        ifc.i_op = 3'd7;
        @(negedge clk);
        ifc.i_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (ifc.o_hi !== h0 || ifc.o_lo !== l0 || ifc.o_busy !== 1'b0 || ifc.o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL noop_ops: hi=%h lo=%h busy=%b done=%b, want %h %h 0 0",
                     ifc.o_hi, ifc.o_lo, ifc.o_busy, ifc.o_done, h0, l0);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] hi, lo; int lat, bcnt; bit held, seen;
        @(negedge clk);
        ifc.i_start = 1'b1; ifc.i_op = 3'd1; ifc.i_rs = 32'hFFFFFFFF; ifc.i_rt = 32'h12345678;
        @(negedge clk);
        ifc.i_start = 1'b0;
        repeat (9) @(negedge clk);
        vectors++;
        if (ifc.o_busy !== 1'b1) begin
            miscompares++; $display("FAIL busy_mid_iter: busy=%b, want 1", ifc.o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ifc.o_busy, ifc.o_done, ifc.o_hi, ifc.o_lo} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, want all zero",
                     ifc.o_busy, ifc.o_done, ifc.o_hi, ifc.o_lo);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ifc.o_busy, ifc.o_done, ifc.o_hi, ifc.o_lo} !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle: busy=%b done=%b hi=%h lo=%h, want all zero",
                     ifc.o_busy, ifc.o_done, ifc.o_hi, ifc.o_lo);
        end
        run_op(3'd3, 32'd9, 32'd4, hi, lo, lat, bcnt, held, seen);
        vectors++;
        if (!seen || hi !== 32'd1 || lo !== 32'd2 || lat !== 33) begin
            miscompares++;
            $display("FAIL divu_after_reset: hi=%h lo=%h lat=%0d, want 00000001 00000002 33", hi, lo, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.i_start = 1'b0;
        ifc.i_op    = 3'd0;
        ifc.i_rs    = '0;
        ifc.i_rt    = '0;
        test_reset();
        test_mult_latency();
        test_directed();
        test_back_to_back();
        test_random();
        test_busy_ignore();
        test_mtlo();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
